irq_ctrl: RTL and testbench

//   External interrupt controller directly upstream of cp0. Synchronises N_SRC

---
 rtl/irq_ctrl.sv | 118 +++++++++++
 tb/tb_irq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: external interrupt controller sitting directly upstream of cp0.
//   Synchronises N_SRC asynchronous interrupt lines, latches their rising edges
//   as pending, applies a software mask and requests the lowest-index eligible
//   source. ir_out is a clean request level held from request until cp0 takes it,
//   with at least two low cycles before every re-assertion.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   irq_src           raw asynchronous interrupt lines (rising-edge sensitive)
//   mask_we/wdata     mask register write port; mask is the current value
//   pending           latched pending flags
//   taken             cp0 accepted the request
//   eret_done         handler returned
//   ir_out            request to cp0 ir_in
//   ir_id             index of the source being requested/serviced
//   busy              controller is not idle
module irq_ctrl #(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned ID_W        = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  input  logic             taken,
  input  logic             eret_done,
  output logic             ir_out,
  output logic [ID_W-1:0]  ir_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE, GAP} state_t;

  state_t           state, state_nxt;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  winner;
  logic             any_eligible;

  // Synchroniser chain plus one delay flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_d <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;

  // Clear only the committed source, and only when cp0 takes it in REQ
  always_comb begin
    clr = '0;
    if (state == REQ && taken) clr[ir_id] = 1'b1;
  end

  // A new edge in the same cycle as the clear keeps the bit pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;
    end
  end

  assign eligible     = pending & mask;
  assign any_eligible = |eligible;

  // Lowest set index wins: scan downwards so the last hit is the lowest
  always_comb begin
    winner = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (eligible[i-1]) winner = ID_W'(i - 1);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_eligible) state_nxt = REQ;
      REQ:     if (taken)        state_nxt = SERVICE;
      SERVICE: if (eret_done)    state_nxt = GAP;
      GAP:                       state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // ir_id is committed on IDLE->REQ and held until the next request
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               ir_id <= '0;
    else if (state == IDLE && any_eligible) ir_id <= winner;
  end

  // Outputs
  always_comb begin
    ir_out = (state == REQ);
    busy   = (state != IDLE);
  end

endmodule

// File: tb/tb_irq_ctrl.sv
`timescale 1ns/1ps
module tb_irq_ctrl;
  localparam int N = 8;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irq_src = '0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = '0;
  logic [7:0] mask, pending;
  logic       taken = 1'b0;
  logic       eret_done = 1'b0;
  logic       ir_out, busy;
  logic [2:0] ir_id;

  always #5 clk = ~clk;

  irq_ctrl #(.N_SRC(8), .ID_W(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .mask(mask), .pending(pending), .taken(taken),
    .eret_done(eret_done), .ir_out(ir_out), .ir_id(ir_id), .busy(busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending/mask as bit vectors, the input history as an
  // array of per-clock samples, and the request lifecycle as flags + a
  // quiet-cycle counter. Every request it issues is queued for the monitor.
  typedef struct packed { int id; int cyc; } req_t;
  req_t       exp_q[$];
  req_t       e;
  logic [7:0] hist [S+1];
  logic [7:0] m_pend = '0, m_mask = '0;
  bit         m_req = 0, m_svc = 0;
  int         m_hold = 0, m_cur = 0, cyc = 0;

  function automatic int lowest(logic [7:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    for (int k = 0; k <= S; k++) hist[k] = '0;
    forever begin
      logic [7:0] rs, nxt;
      int win;
      @(posedge clk or posedge rst);
      cyc++;
      if (rst) begin
        m_pend = '0; m_mask = '0; m_req = 0; m_svc = 0; m_hold = 0; m_cur = 0;
        for (int k = 0; k <= S; k++) hist[k] = '0;
        exp_q.delete();
      end else begin
        // edge seen by the pending logic = sample S clocks ago, not S+1 clocks ago
        rs  = hist[S-1] & ~hist[S];
        win = lowest(m_pend & m_mask);
        nxt = m_pend;
        if (m_req) begin
          if (taken) begin nxt[m_cur] = 1'b0; m_req = 0; m_svc = 1; end
        end else if (m_svc) begin
          if (eret_done) begin m_svc = 0; m_hold = 1; end
        end else if (m_hold > 0) begin
          m_hold--;
        end else if (win >= 0) begin
          m_req = 1; m_cur = win;
          exp_q.push_back('{id: win, cyc: cyc});
        end
        m_pend = nxt | rs;
        if (mask_we) m_mask = mask_wdata;
        for (int k = S; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = irq_src;
      end
    end
  end

  // Monitor: compares state every cycle and pops a queued request on each
  // rising ir_out
  bit prev_ir = 0, seen = 0;
  int low_run = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ir = 0; seen = 0; low_run = 0;
      end else begin
        chk("pending", int'(pending), int'(m_pend));
        chk("mask", int'(mask), int'(m_mask));
        chk("busy", int'(busy), int'(m_req | m_svc | (m_hold > 0)));
        chk("ir_out", int'(ir_out), int'(m_req));
        if (ir_out && !prev_ir) begin
          chk("req_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ir_id", int'(ir_id), e.id);
            chk("req_cycle", cyc, e.cyc);
            if (seen) chk("low_gap_ge2", int'(low_run >= 2), 1);
          end
          seen = 1; low_run = 0;
        end else if (!ir_out) begin
          low_run++;
        end
        prev_ir = ir_out;
      end
    end
  end

  bit auto_ack = 0;

  task automatic tick();
    @(negedge clk);
    mask_we   = 1'b0;
    taken     = auto_ack && ($urandom_range(0, 3) == 0);
    eret_done = auto_ack && ($urandom_range(0, 3) == 0);
  endtask

  task automatic wr_mask(logic [7:0] v);
    tick();
    mask_we = 1'b1; mask_wdata = v;
  endtask

  task automatic pulse(logic [7:0] bits, int hold);
    tick();
    irq_src = irq_src | bits;
    repeat (hold) tick();
    irq_src = irq_src & ~bits;
  endtask

  task automatic wait_model_req(int budget);
    int g = 0;
    while (!m_req && g < budget) begin tick(); g++; end
    chk("req_within_budget", int'(m_req), 1);
  endtask

  initial begin
    int g;
    #1 rst = 1'b1;
    #1;
    chk("rst_ir_out", int'(ir_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_mask", int'(mask), 0);
    chk("rst_ir_id", int'(ir_id), 0);
    tick(); tick();
    rst = 1'b0;

    // single source, single request
    auto_ack = 1;
    wr_mask(8'h01);
    pulse(8'h01, 2);
    repeat (25) tick();

    // simultaneous edges: lower index first, then the other after ERET+GAP
    wr_mask(8'hFF);
    pulse(8'h24, 3);
    repeat (60) tick();

    // masked source stays pending, unmasking releases it
    wr_mask(8'h00);
    pulse(8'h08, 2);
    repeat (10) tick();
    wr_mask(8'h08);
    repeat (30) tick();

    // committed request survives a higher-priority arrival and masking
    auto_ack = 0;
    tick();
    wr_mask(8'hFF);
    pulse(8'h02, 2);
    wait_model_req(20);
    pulse(8'h01, 2);
    wr_mask(8'h00);
    repeat (6) tick();
    chk("committed_id", int'(ir_id), 1);
    chk("committed_ir_out", int'(ir_out), 1);
    wr_mask(8'hFF);
    auto_ack = 1;
    repeat (60) tick();

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      tick();
      if ($urandom_range(0, 5) == 0) irq_src[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) begin
        mask_we = 1'b1; mask_wdata = 8'($urandom | $urandom);
      end
    end

    // asynchronous reset while in SERVICE
    irq_src = '0;
    wr_mask(8'hFF);
    pulse(8'h40, 2);
    g = 0;
    while (!m_svc && g < 300) begin tick(); g++; end
    auto_ack = 0; taken = 1'b0; eret_done = 1'b0;
    chk("reach_service", int'(m_svc), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_ir_out", int'(ir_out), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_pending", int'(pending), 0);
    chk("async_mask", int'(mask), 0);
    tick(); tick();
    rst = 1'b0;

    // taken / eret_done while idle must not move the controller
    for (int i = 0; i < 12; i++) begin
      tick();
      taken = 1'b1; eret_done = (i % 2 == 0);
    end
    tick();
    chk("idle_busy", int'(busy), 0);
    chk("idle_ir_out", int'(ir_out), 0);

    auto_ack = 1;
    repeat (30) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
